// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        STARTUP,
        RELEASE,
        RUN,
        SOFT
    } rst_seq_state_e;

    // Width of the shared delay counter: wide enough to hold the longest wait.
    function automatic int cnt_width(input int startup_dly, input int gap_cycles,
                                     input int soft_hold);
        int m;
        m = startup_dly;
        if (gap_cycles > m) m = gap_cycles;
        if (soft_hold > m) m = soft_hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously, de-asserts after SYNC_STAGES clk edges.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic reset_sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign reset_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Board-reset sequencer: synchronises rstb, waits a start-up delay, then releases
// NUM_CH domain resets in order; a soft-reset edge re-asserts all and replays.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STARTUP_DLY = 16,
    parameter int GAP_CYCLES  = 5,
    parameter int SOFT_HOLD   = 3,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              soft_rst_i,
    output logic [NUM_CH-1:0] rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  soft_cnt_o
);

    localparam int CTR_W = cnt_width(STARTUP_DLY, GAP_CYCLES, SOFT_HOLD);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CTR_W-1:0]  STARTUP_LAST = CTR_W'(STARTUP_DLY - 1);
    localparam logic [CTR_W-1:0]  GAP_LAST     = CTR_W'(GAP_CYCLES - 1);
    localparam logic [CTR_W-1:0]  SOFT_LAST    = CTR_W'(SOFT_HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] FIRST_BIT    = NUM_CH'(1);

    logic reset_sync_n;

    rst_seq_state_e     state_q, state_d;
    logic [CTR_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0]  rst_n_q, rst_n_d;
    logic               done_q, done_d;
    logic               busy_q;
    logic [CNT_W-1:0]   soft_cnt_q, soft_cnt_d;
    logic               soft_q;
    logic               soft_edge;
    logic               release_first;

    rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk         (clk),
        .rst_n       (rstb),
        .reset_sync_n(reset_sync_n)
    );

    assign soft_edge = soft_rst_i & ~soft_q;

    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        rst_n_d       = rst_n_q;
        done_d        = done_q;
        soft_cnt_d    = soft_cnt_q;
        release_first = 1'b0;

        case (state_q)
            HOLD: begin
                if (reset_sync_n) begin
                    state_d = STARTUP;
                    cnt_d   = '0;
                end
            end
            STARTUP: begin
                if (cnt_q == STARTUP_LAST) release_first = 1'b1;
                else                       cnt_d = cnt_q + CTR_W'(1);
            end
            RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    // Domains release as a thermometer code, bit 0 first.
                    rst_n_d = (rst_n_q << 1) | FIRST_BIT;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CTR_W'(1);
                end
            end
            RUN: begin
            end
            SOFT: begin
                if (cnt_q == SOFT_LAST) release_first = 1'b1;
                else                    cnt_d = cnt_q + CTR_W'(1);
            end
            default: state_d = HOLD;
        endcase

        if (release_first) begin
            rst_n_d = FIRST_BIT;
            cnt_d   = '0;
            idx_d   = IDX_W'(1);
            if (NUM_CH == 1) begin
                done_d  = 1'b1;
                state_d = RUN;
            end else begin
                state_d = RELEASE;
            end
        end

        // A soft edge wins over any progress made this cycle.
        if (soft_edge && (state_q != HOLD)) begin
            state_d = SOFT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
            if (soft_cnt_q != {CNT_W{1'b1}}) soft_cnt_d = soft_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_n_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            soft_cnt_q <= '0;
            soft_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_n_q    <= rst_n_d;
            done_q     <= done_d;
            busy_q     <= ~done_d;
            soft_cnt_q <= soft_cnt_d;
            soft_q     <= soft_rst_i;
        end
    end

    assign rst_n_o    = rst_n_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;
    assign soft_cnt_o = soft_cnt_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: default instance plus a NUM_CH=1/GAP=1/CNT_W=2 instance,
// both compared every cycle against a release-schedule model.
module tb_rst_sequencer;

    localparam int SYNC  = 2;
    localparam int DLY   = 16;
    localparam int HOLDC = 3;
    localparam int T0    = SYNC + 1;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic soft_rst_i = 1'b0;

    logic [3:0] rst_n_a;
    logic       busy_a, done_a;
    logic [7:0] cnt_a;
    logic [0:0] rst_n_b;
    logic       busy_b, done_b;
    logic [1:0] cnt_b;

    rst_sequencer dut_a (
        .clk       (clk),
        .rstb      (rstb),
        .soft_rst_i(soft_rst_i),
        .rst_n_o   (rst_n_a),
        .busy_o    (busy_a),
        .done_o    (done_a),
        .soft_cnt_o(cnt_a)
    );

    rst_sequencer #(
        .NUM_CH    (1),
        .GAP_CYCLES(1),
        .CNT_W     (2)
    ) dut_b (
        .clk       (clk),
        .rstb      (rstb),
        .soft_rst_i(soft_rst_i),
        .rst_n_o   (rst_n_b),
        .busy_o    (busy_b),
        .done_o    (done_b),
        .soft_cnt_o(cnt_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: edges since rstb rose; the active release schedule starts at edge
    // anchor+dly and adds one domain every gap edges.
    int   since_rise = 0;
    int   anchor     = 0;
    int   dly        = 0;
    int   accepted   = 0;
    logic prev_soft  = 1'b0;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            since_rise <= 0;
            anchor     <= 0;
            dly        <= 0;
            accepted   <= 0;
            prev_soft  <= 1'b0;
        end else begin
            if (since_rise + 1 == T0) begin
                anchor <= T0;
                dly    <= DLY;
            end else if ((since_rise + 1 > T0) && soft_rst_i && !prev_soft) begin
                anchor   <= since_rise + 1;
                dly      <= HOLDC;
                accepted <= accepted + 1;
            end
            since_rise <= since_rise + 1;
            prev_soft  <= soft_rst_i;
        end
    end

    function automatic logic [31:0] exp_rst(input int nch, input int gap);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < nch; k++)
            if (since_rise >= T0 && since_rise >= anchor + dly + k * gap) v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] exp_cnt(input int cmax);
        return (accepted > cmax) ? cmax : accepted;
    endfunction

    bit check_en = 1'b1;

    always @(negedge clk) begin
        if (check_en) begin
            check("a rst_n",  rst_n_a, exp_rst(4, 5));
            check("a done",   done_a,  exp_rst(4, 5) == 32'hF);
            check("a busy",   busy_a,  exp_rst(4, 5) != 32'hF);
            check("a cnt",    cnt_a,   exp_cnt(255));
            check("b rst_n",  rst_n_b, exp_rst(1, 1));
            check("b done",   done_b,  exp_rst(1, 1) == 32'h1);
            check("b cnt",    cnt_b,   exp_cnt(3));
            check("b done=rst_n0", done_b, rst_n_b[0]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int len);
        soft_rst_i = 1'b1;
        tick(len);
        soft_rst_i = 1'b0;
        tick(1);
    endtask

    task automatic async_reset();
        rstb = 1'b0;
        #1;
        check("async rst_n_a", rst_n_a, 0);
        check("async cnt_a",   cnt_a,   0);
        check("async busy_a",  busy_a,  1);
        check("async rst_n_b", rst_n_b, 0);
        tick(1);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done_a && cycles < budget) begin
            tick(1);
            cycles++;
        end
        check("done within budget", done_a, 1);
    endtask

    int cyc;

    initial begin
        // Power-on: release latency from rstb rise to done is t0+31 edges.
        #22 rstb = 1'b1;
        wait_done(100, cyc);
        check("poweron done latency", cyc, T0 + 31);

        // Single soft pulse in RUN.
        tick(5);
        pulse(1);
        tick(25);
        check("soft in run cnt", cnt_a, 1);

        // Soft during RELEASE at t0+22.
        async_reset();
        rstb = 1'b1;
        tick(24);
        check("bits 0-1 released", rst_n_a, 4'b0011);
        soft_rst_i = 1'b1;
        tick(1);
        soft_rst_i = 1'b0;
        check("soft mid-release clears", rst_n_a, 4'b0000);
        tick(2);
        check("replay not yet", rst_n_a, 4'b0000);
        tick(1);
        check("replay bit0 at t0+25", rst_n_a, 4'b0001);

        // Re-trigger inside SOFT two cycles after the first edge.
        wait_done(100, cyc);
        pulse(1);
        pulse(1);
        check("retrigger cnt", cnt_a, 3);
        tick(1);
        check("hold extended", rst_n_a, 4'b0000);
        tick(1);
        check("release after retrigger", rst_n_a, 4'b0001);

        // Async reset mid-release, then full start-up replay.
        wait_done(100, cyc);
        async_reset();
        rstb = 1'b1;
        tick(25);
        async_reset();
        rstb = 1'b1;
        wait_done(100, cyc);
        check("replay done latency", cyc, T0 + 31);

        // Saturation on the narrow-counter instance.
        for (int i = 0; i < 5; i++) begin
            pulse(1);
            tick(1);
        end
        check("b cnt saturated", cnt_b, 3);
        check("a cnt five", cnt_a, 5);

        // Randomised soft pulses and async resets.
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rstb = 1'b0;
                tick($urandom_range(0, 3));
                rstb = 1'b1;
                tick(1);
            end else if (r < 6) begin
                pulse($urandom_range(1, 3));
            end else begin
                tick($urandom_range(1, 30));
            end
        end
        tick(40);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised reset controller between the board reset pin and the SoC clock domains of top_fpga.
- Synchronises the asynchronous active-low board reset, waits a start-up delay, then releases NUM_CH active-low domain resets in fixed order, one every GAP_CYCLES cycles.
- Supports an in-domain soft-reset request that re-asserts all domains and replays the staged release.
- Replaces the fixed "hold reset, wait, pulse soft reset" bring-up used in simulation with synthesizable, configurable logic.

Parameters:
- NUM_CH, 4: number of reset domains; range 1..16.
- SYNC_STAGES, 2: depth of the reset de-assertion synchroniser; minimum 2.
- STARTUP_DLY, 16: cycles from synchronised release to release of domain 0; minimum 1.
- GAP_CYCLES, 5: cycles between release of domain k-1 and domain k; minimum 1.
- SOFT_HOLD, 3: minimum cycles all domains are held after a soft request; minimum 1.
- CNT_W, 8: width of the saturating soft-reset event counter.

Ports:
- clk  in  1  system clock.
- rstb  in  1  asynchronous, active-low reset.
- soft_rst_i  in  1  soft-reset request, synchronous to clk; rising edge triggers.
- rst_n_o  out  NUM_CH  per-domain active-low reset; bit 0 is released first.
- busy_o  out  1  high while any domain is held or the sequence is in progress.
- done_o  out  1  high when all domains are released.
- soft_cnt_o  out  CNT_W  number of soft resets accepted; saturates at all-ones.

Behaviour:
- rstb low: rst_n_o = 0 asynchronously, busy_o = 1, done_o = 0, soft_cnt_o = 0, FSM in HOLD, all counters 0, soft edge register 0.
- Synchroniser: rstb rise propagates through SYNC_STAGES flops. Let t0 be the first posedge at which the synchronised reset reads high.
- FSM states:
  - HOLD -> STARTUP at t0.
  - STARTUP: count STARTUP_DLY cycles.
  - RELEASE: release domains in order with index idx.
  - RUN: all domains released.
  - SOFT: soft-reset hold.
- Release timing: rst_n_o[0] rises at edge t0+STARTUP_DLY. rst_n_o[k] rises at edge t0+STARTUP_DLY+k*GAP_CYCLES. Bits never fall except on reset or soft request.
- done_o rises on the same edge as rst_n_o[NUM_CH-1]. busy_o = ~done_o. All outputs are registered.
- Soft-edge detect: soft_rst_i high at edge e and low at edge e-1.
  - At edge e: rst_n_o = 0, done_o = 0, FSM enters SOFT, hold counter cleared, soft_cnt_o increments unless saturated.
  - Accepted in STARTUP, RELEASE, RUN and SOFT. In SOFT, a new edge restarts the hold counter and still counts.
  - Ignored in HOLD.
  - A level held high is not re-triggered.
- Soft release timing: after the hold, STARTUP_DLY is skipped. rst_n_o[0] rises at e+SOFT_HOLD and rst_n_o[k] at e+SOFT_HOLD+k*GAP_CYCLES.
- rstb assertion at any time overrides everything, including SOFT and mid-sequence. Outputs fall immediately and soft_cnt_o clears.
- Counter width: clog2(max(STARTUP_DLY, GAP_CYCLES, SOFT_HOLD)+1). idx width: clog2(NUM_CH), minimum 1.
- NUM_CH = 1: done_o rises with rst_n_o[0].

Decomposition:
- Package rst_seq_pkg:
  - state enum rst_seq_state_e {HOLD, STARTUP, RELEASE, RUN, SOFT};
  - function for the counter width.
- Sub-module rst_sync:
  - async-assert, sync-deassert synchroniser, parametrised by SYNC_STAGES;
  - output reset_sync_n;
  - reused by other domain crossings.

Test Plan (defaults unless stated):
1. Power-on: rstb low 20 ns, then high. Expect:
   - rst_n_o = 4'b0000 through t0+15;
   - rst_n_o[0] at t0+16, [1] at t0+21, [2] at t0+26, [3] at t0+31;
   - done_o = 1 at t0+31.
2. Soft pulse in RUN: 1-cycle soft_rst_i at edge e. Expect:
   - rst_n_o = 0 at e;
   - bits release at e+3, e+8, e+13, e+18;
   - soft_cnt_o = 1.
3. Soft during RELEASE: request at t0+22, after bits 0-1 are released. Expect:
   - all bits low at the request edge;
   - replay from bit 0 at t0+25.
4. Re-trigger in SOFT: second rising edge 2 cycles after the first. Expect:
   - hold extends to second edge +3;
   - soft_cnt_o = 2.
5. Async reset mid-sequence: rstb low between clock edges during RELEASE. Expect:
   - rst_n_o = 0 and soft_cnt_o = 0 before the next edge;
   - full start-up sequence replays after rstb rises.
6. Parameter sweep with NUM_CH=1, GAP_CYCLES=1, CNT_W=2. Expect:
   - done_o coincident with rst_n_o[0];
   - five soft pulses leave soft_cnt_o saturated at 3.
